// File: rtl/div_share_ctrl_if.sv
// Request/response bundle for the shared divider: per-requester valid/ready with packed
// operands in, and one tagged response port out.
interface div_share_ctrl_if #(
    parameter int WIDTH   = 16,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_numer;
    logic [NUM_REQ*WIDTH-1:0] req_denom;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic [WIDTH-1:0]         rsp_quotient;
    logic [WIDTH-1:0]         rsp_remain;
    logic                     rsp_div0;
    logic                     busy;

    modport slave (
        input  req_valid, req_numer, req_denom, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remain, rsp_div0, busy
    );

    modport master (
        output req_valid, req_numer, req_denom, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remain, rsp_div0, busy
    );
endinterface

// File: rtl/div_share_ctrl.sv
// One restoring divider (one quotient bit per clock) time-shared between NUM_REQ requesters
// with round-robin grant; each response carries the id of the requester that issued it.
module div_share_ctrl #(
    parameter int WIDTH   = 16,
    parameter int NUM_REQ = 4
) (
    input  logic             clk,
    input  logic             rst,
    div_share_ctrl_if.slave  bus
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   numer_q, numer_d;
    logic [WIDTH-1:0]   denom_q, denom_d;
    logic [WIDTH-1:0]   quot_q, quot_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               div0_q, div0_d;

    logic               grant_vld;
    logic [ID_W-1:0]    grant_id;
    logic [NUM_REQ-1:0] req_ready_w;
    logic [WIDTH-1:0]   sel_numer;
    logic [WIDTH-1:0]   sel_denom;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH-1:0]   rem_sub;
    logic               rem_ge;

    // Scan from the farthest offset down so the requester closest to ptr wins last.
    always_comb begin
        int              idx;
        logic [ID_W-1:0] cand;
        grant_vld = 1'b0;
        grant_id  = '0;
        idx       = 0;
        cand      = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            idx = int'(ptr_q) + j;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            cand = ID_W'(idx);
            if (bus.req_valid[cand]) begin
                grant_vld = 1'b1;
                grant_id  = cand;
            end
        end
    end

    always_comb begin
        req_ready_w = '0;
        if (state_q == S_IDLE && grant_vld) req_ready_w[grant_id] = 1'b1;
    end

    assign sel_numer = bus.req_numer[grant_id*WIDTH +: WIDTH];
    assign sel_denom = bus.req_denom[grant_id*WIDTH +: WIDTH];

    // Partial remainder stays below denom, so only the shifted value needs the extra bit.
    assign rem_shift = {rem_q, numer_q[cnt_q]};
    assign rem_ge    = (rem_shift >= {1'b0, denom_q});
    assign rem_sub   = rem_shift[WIDTH-1:0] - denom_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        numer_d = numer_q;
        denom_d = denom_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        div0_d  = div0_q;
        case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    numer_d = sel_numer;
                    denom_d = sel_denom;
                    id_d    = grant_id;
                    cnt_d   = CNT_W'(WIDTH - 1);
                    if (sel_denom == '0) begin
                        quot_d  = '1;
                        rem_d   = sel_numer;
                        div0_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        quot_d  = '0;
                        rem_d   = '0;
                        div0_d  = 1'b0;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                rem_d         = rem_ge ? rem_sub : rem_shift[WIDTH-1:0];
                quot_d[cnt_q] = rem_ge;
                if (cnt_q == '0) state_d = S_DONE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            S_DONE: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                    ptr_d   = (int'(id_q) == NUM_REQ - 1) ? '0 : id_q + ID_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
            numer_q <= '0;
            denom_q <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            numer_q <= numer_d;
            denom_q <= denom_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            div0_q  <= div0_d;
        end
    end

    assign bus.req_ready    = req_ready_w;
    assign bus.rsp_valid    = (state_q == S_DONE);
    assign bus.rsp_id       = id_q;
    assign bus.rsp_quotient = quot_q;
    assign bus.rsp_remain   = rem_q;
    assign bus.rsp_div0     = div0_q;
    assign bus.busy         = (state_q != S_IDLE);
endmodule

// File: tb/tb_div_share_ctrl.sv
// Directed bench for the shared divider: latency, div-by-zero, round-robin order,
// response back-pressure, mid-job reset and operand edge cases.
module tb_div_share_ctrl;
    localparam int WIDTH   = 16;
    localparam int NUM_REQ = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    div_share_ctrl_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) bus();

    div_share_ctrl #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in cycle 1 after the accept edge; returns the cycle in which rsp_valid is seen.
    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!bus.rsp_valid && lat < 64) begin
            tick();
            lat++;
        end
    endtask

    task automatic set_ops(input int id, input logic [15:0] n, input logic [15:0] d);
        bus.req_numer[id*WIDTH +: WIDTH] = n;
        bus.req_denom[id*WIDTH +: WIDTH] = d;
    endtask

    task automatic do_job(input string tag, input int id, input logic [15:0] n, input logic [15:0] d,
                          input logic [15:0] eq, input logic [15:0] er, input logic ediv0);
        int lat;
        int elat;
        elat = (d == 16'd0) ? 1 : WIDTH + 1;
        set_ops(id, n, d);
        bus.req_valid = NUM_REQ'(1) << id;
        #1;
        check({tag, "_grant"}, 32'(bus.req_ready), 32'(NUM_REQ'(1) << id));
        tick();
        bus.req_valid = '0;
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        wait_rsp(lat);
        check({tag, "_lat"}, 32'(lat), 32'(elat));
        check({tag, "_q"}, 32'(bus.rsp_quotient), 32'(eq));
        check({tag, "_r"}, 32'(bus.rsp_remain), 32'(er));
        check({tag, "_id"}, 32'(bus.rsp_id), 32'(id));
        check({tag, "_div0"}, 32'(bus.rsp_div0), 32'(ediv0));
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check({tag, "_drop"}, 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        int lat;
        logic [15:0] n;
        logic [15:0] d;
        logic [15:0] eq;
        logic [15:0] er;

        bus.req_valid = '0;
        bus.req_numer = '0;
        bus.req_denom = '0;
        bus.rsp_ready = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(bus.req_ready), 32'd0);
        check("rst_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_id", 32'(bus.rsp_id), 32'd0);
        check("rst_q", 32'(bus.rsp_quotient), 32'd0);
        check("rst_r", 32'(bus.rsp_remain), 32'd0);
        check("rst_div0", 32'(bus.rsp_div0), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        tick();

        do_job("t1", 0, 16'd100, 16'd7, 16'd14, 16'd2, 1'b0);
        do_job("t2", 2, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1);

        // Response held off for 5 cycles while another requester is waiting.
        set_ops(3, 16'd1000, 16'd10);
        bus.req_valid = 4'b1000;
        tick();
        bus.req_valid = 4'b0001;
        wait_rsp(lat);
        check("t4_lat", 32'(lat), 32'd17);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t4_valid", 32'(bus.rsp_valid), 32'd1);
            check("t4_q", 32'(bus.rsp_quotient), 32'd100);
            check("t4_r", 32'(bus.rsp_remain), 32'd0);
            check("t4_id", 32'(bus.rsp_id), 32'd3);
            check("t4_ready", 32'(bus.req_ready), 32'd0);
            check("t4_busy", 32'(bus.busy), 32'd1);
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        bus.req_valid = '0;
        check("t4_drop", 32'(bus.rsp_valid), 32'd0);

        // All requesters valid; pointer is 0 after the job on req3.
        set_ops(0, 16'd1000, 16'd3);
        set_ops(1, 16'd1077, 16'd4);
        set_ops(2, 16'd1154, 16'd5);
        set_ops(3, 16'd1231, 16'd6);
        bus.req_valid = 4'b1111;
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            int g;
            g = k % NUM_REQ;
            check("t3_grant", 32'(bus.req_ready), 32'(4'b0001 << g));
            tick();
            wait_rsp(lat);
            check("t3_lat", 32'(lat), 32'd17);
            check("t3_id", 32'(bus.rsp_id), 32'(g));
            case (g)
                0: begin eq = 16'd333; er = 16'd1; end
                1: begin eq = 16'd269; er = 16'd1; end
                2: begin eq = 16'd230; er = 16'd4; end
                default: begin eq = 16'd205; er = 16'd1; end
            endcase
            check("t3_q", 32'(bus.rsp_quotient), 32'(eq));
            check("t3_r", 32'(bus.rsp_remain), 32'(er));
            tick();
        end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;

        do_job("e1", 1, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0);
        do_job("e2", 2, 16'd5, 16'd9, 16'd0, 16'd5, 1'b0);
        do_job("e3", 0, 16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 1'b0);
        do_job("e4", 3, 16'd0, 16'd0, 16'hFFFF, 16'd0, 1'b1);
        for (int k = 0; k < 6; k++) begin
            n = 16'($urandom_range(0, 65535));
            d = (k == 2) ? 16'd0 : 16'($urandom_range(1, (k < 3) ? 255 : 65535));
            eq = (d == 16'd0) ? 16'hFFFF : n / d;
            er = (d == 16'd0) ? n : n % d;
            do_job("rnd", k % NUM_REQ, n, d, eq, er, d == 16'd0);
        end

        // Reset in cycle 8 of a job on req3, then all valid must grant req0 first.
        set_ops(3, 16'h5555, 16'd3);
        bus.req_valid = 4'b1000;
        tick();
        bus.req_valid = '0;
        repeat (7) tick();
        check("t5_busy_pre", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        check("t5_valid", 32'(bus.rsp_valid), 32'd0);
        check("t5_busy", 32'(bus.busy), 32'd0);
        check("t5_ready", 32'(bus.req_ready), 32'd0);
        #2 rst = 1'b0;
        tick();
        set_ops(0, 16'd50, 16'd6);
        bus.req_valid = 4'b1111;
        #1;
        check("t5_grant", 32'(bus.req_ready), 32'd1);
        tick();
        bus.req_valid = '0;
        wait_rsp(lat);
        check("t5_lat", 32'(lat), 32'd17);
        check("t5_id", 32'(bus.rsp_id), 32'd0);
        check("t5_q", 32'(bus.rsp_quotient), 32'd8);
        check("t5_r", 32'(bus.rsp_remain), 32'd2);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check("t5_drop", 32'(bus.rsp_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
